// File: rtl/timekeeper_hms_pkg.sv
// Shared time-of-day types, field moduli and load validation for timekeeper_hms.
// Build option: TIMEKEEPER_ALARM_EN adds the alarm comparator to the top level.
package timekeeper_pkg;

    localparam int SEC_PER_MIN  = 60;
    localparam int MIN_PER_HOUR = 60;
    localparam int HOUR_PER_DAY = 24;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } hms_t;

    function automatic logic hms_valid(input hms_t t);
        return (t.hour   < 8'(HOUR_PER_DAY)) &&
               (t.minute < 8'(MIN_PER_HOUR)) &&
               (t.second < 8'(SEC_PER_MIN));
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MODULO field counter advancing by 0..2 per cycle, with load priority and wrap carry.
// Build option: TIMEKEEPER_ALARM_EN exposes the next-state value for the alarm comparator.
module wrap_counter #(
    parameter int MODULO = 60
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] step,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry
`ifdef TIMEKEEPER_ALARM_EN
    ,
    output logic [7:0] next_value
`endif
);

    logic [7:0] r_value;
    logic [7:0] w_next;
    logic [8:0] w_sum;
    logic       w_over;

    // value <= MODULO-1 and step <= 2, so one conditional subtraction always lands in range.
    assign w_sum  = {1'b0, r_value} + {7'b0, step};
    assign w_over = (w_sum >= 9'(MODULO));

    always_comb begin
        // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
        w_next = r_value;
        if (load) begin
            w_next = load_val;
        end else if (en) begin
            w_next = w_over ? 8'(w_sum - 9'(MODULO)) : w_sum[7:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_value <= '0;
        end else begin
            r_value <= w_next;
        end
    end

    assign value = r_value;
    assign carry = en && !load && w_over;
`ifdef TIMEKEEPER_ALARM_EN
    assign next_value = w_next;
`endif

endmodule

// File: rtl/timekeeper_hms.sv
// Hours/minutes/seconds time-of-day counter with prescaler, validated atomic load and increment buttons.
// Build option: TIMEKEEPER_ALARM_EN compiles in the alarm ports and comparator.
module timekeeper_hms
    import timekeeper_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] load_hour,
    input  logic [7:0] load_minute,
    input  logic [7:0] load_second,
    input  logic       inc_hour,
    input  logic       inc_minute,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       sec_pulse,
    output logic       load_err
`ifdef TIMEKEEPER_ALARM_EN
    ,
    input  logic       alarm_arm,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_minute,
    input  logic       alarm_ack,
    output logic       alarm
`endif
);

    localparam int PRE_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;

    logic [PRE_W-1:0] r_pre;
    logic             r_sec_pulse;
    logic             r_load_err;
    logic             r_inc_hour_q;
    logic             r_inc_min_q;

    hms_t w_load_val;
    logic w_load_ok;
    logic w_tick;
    logic w_inc_hour_edge;
    logic w_inc_min_edge;
    logic w_sec_carry;
    logic w_min_carry;
    logic w_min_to_hour;
    logic w_unused_day_carry;
    logic [1:0] w_min_step;
    logic [1:0] w_hour_step;

    assign w_load_val      = {load_hour, load_minute, load_second};
    assign w_load_ok       = load && hms_valid(w_load_val);
    assign w_tick          = run && (r_pre == PRE_W'(CLK_HZ - 1));
    assign w_inc_hour_edge = inc_hour && !r_inc_hour_q;
    assign w_inc_min_edge  = inc_minute && !r_inc_min_q;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_pre        <= '0;
            r_sec_pulse  <= 1'b0;
            r_load_err   <= 1'b0;
            r_inc_hour_q <= 1'b0;
            r_inc_min_q  <= 1'b0;
        end else begin
            if (w_load_ok || w_tick) begin
                r_pre <= '0;
            end else if (run) begin
                r_pre <= r_pre + PRE_W'(1);
            end
            r_sec_pulse  <= w_tick && !w_load_ok;
            r_load_err   <= load && !w_load_ok;
            r_inc_hour_q <= inc_hour;
            r_inc_min_q  <= inc_minute;
        end
    end

    // A minute button press absorbs the seconds carry and never ripples into the hour.
    assign w_min_step    = {1'b0, w_sec_carry} + {1'b0, w_inc_min_edge};
    assign w_min_to_hour = w_min_carry && !w_inc_min_edge;
    assign w_hour_step   = {1'b0, w_min_to_hour} + {1'b0, w_inc_hour_edge};

`ifdef TIMEKEEPER_ALARM_EN
    logic [7:0] w_next_s;
    logic [7:0] w_next_m;
    logic [7:0] w_next_h;
`endif

    wrap_counter #(.MODULO(SEC_PER_MIN)) u_sec (
        .clock    (clock),
        .rst      (rst),
        .en       (w_tick),
        .step     (2'd1),
        .load     (w_load_ok),
        .load_val (load_second),
        .value    (second),
        .carry    (w_sec_carry)
`ifdef TIMEKEEPER_ALARM_EN
        ,
        .next_value (w_next_s)
`endif
    );

    wrap_counter #(.MODULO(MIN_PER_HOUR)) u_min (
        .clock    (clock),
        .rst      (rst),
        .en       (w_sec_carry || w_inc_min_edge),
        .step     (w_min_step),
        .load     (w_load_ok),
        .load_val (load_minute),
        .value    (minute),
        .carry    (w_min_carry)
`ifdef TIMEKEEPER_ALARM_EN
        ,
        .next_value (w_next_m)
`endif
    );

    wrap_counter #(.MODULO(HOUR_PER_DAY)) u_hour (
        .clock    (clock),
        .rst      (rst),
        .en       (w_min_to_hour || w_inc_hour_edge),
        .step     (w_hour_step),
        .load     (w_load_ok),
        .load_val (load_hour),
        .value    (hour),
        .carry    (w_unused_day_carry)
`ifdef TIMEKEEPER_ALARM_EN
        ,
        .next_value (w_next_h)
`endif
    );

    assign sec_pulse = r_sec_pulse;
    assign load_err  = r_load_err;

`ifdef TIMEKEEPER_ALARM_EN
    logic       r_alarm;
    logic [5:0] r_alarm_ticks;
    logic       w_time_update;
    logic       w_alarm_hit;
    logic       w_alarm_clr;

    // Match against the time about to be registered so the alarm rises with the new time.
    assign w_time_update = w_load_ok || w_tick || w_inc_min_edge || w_inc_hour_edge;
    assign w_alarm_hit   = alarm_arm && w_time_update && (w_next_h == alarm_hour) &&
                           (w_next_m == alarm_minute) && (w_next_s == 8'd0);
    assign w_alarm_clr   = alarm_ack || !alarm_arm ||
                           (r_alarm && w_tick && !w_load_ok && (r_alarm_ticks == 6'd59));

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_alarm       <= 1'b0;
            r_alarm_ticks <= '0;
        end else if (w_alarm_clr) begin
            r_alarm       <= 1'b0;
            r_alarm_ticks <= '0;
        end else if (w_alarm_hit) begin
            r_alarm       <= 1'b1;
            r_alarm_ticks <= '0;
        end else if (r_alarm && w_tick && !w_load_ok) begin
            r_alarm_ticks <= r_alarm_ticks + 6'd1;
        end
    end

    assign alarm = r_alarm;
`endif

endmodule

// File: tb/tb_timekeeper_hms.sv
// Directed self-checking bench for timekeeper_hms at CLK_HZ=4 with a queue-based scoreboard.
// Alarm steps are compiled in when TIMEKEEPER_ALARM_EN is defined.
module tb_timekeeper_hms;

    localparam int CLK_HZ = 4;

    logic       clock = 1'b0;
    logic       rst;
    logic       run;
    logic       load;
    logic [7:0] load_hour;
    logic [7:0] load_minute;
    logic [7:0] load_second;
    logic       inc_hour;
    logic       inc_minute;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic       sec_pulse;
    logic       load_err;
`ifdef TIMEKEEPER_ALARM_EN
    logic       alarm_arm;
    logic [7:0] alarm_hour;
    logic [7:0] alarm_minute;
    logic       alarm_ack;
    logic       alarm;
`endif

    timekeeper_hms #(.CLK_HZ(CLK_HZ)) dut (
        .clock       (clock),
        .rst         (rst),
        .run         (run),
        .load        (load),
        .load_hour   (load_hour),
        .load_minute (load_minute),
        .load_second (load_second),
        .inc_hour    (inc_hour),
        .inc_minute  (inc_minute),
        .hour        (hour),
        .minute      (minute),
        .second      (second),
        .sec_pulse   (sec_pulse),
        .load_err    (load_err)
`ifdef TIMEKEEPER_ALARM_EN
        ,
        .alarm_arm    (alarm_arm),
        .alarm_hour   (alarm_hour),
        .alarm_minute (alarm_minute),
        .alarm_ack    (alarm_ack),
        .alarm        (alarm)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic       sp;
        logic       le;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s, input logic sp, input logic le);
        exp_t e;
        e.tag = tag; e.h = h; e.m = m; e.s = s; e.sp = sp; e.le = le;
        sb.push_back(e);
    endtask

    task automatic score();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.tag, ".hour"},      hour,               e.h);
            cmp({e.tag, ".minute"},    minute,             e.m);
            cmp({e.tag, ".second"},    second,             e.s);
            cmp({e.tag, ".sec_pulse"}, {7'b0, sec_pulse},  {7'b0, e.sp});
            cmp({e.tag, ".load_err"},  {7'b0, load_err},   {7'b0, e.le});
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s, input logic sp, input logic le);
        push_exp(tag, h, m, s, sp, le);
        score();
    endtask

    task automatic edge1();
        @(posedge clock);
        #1;
    endtask

    task automatic edges(input int n);
        repeat (n) edge1();
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load = 1'b1; load_hour = h; load_minute = m; load_second = s;
        edge1();
        load = 1'b0;
    endtask

    int n_pulse;
    int found;

    initial begin
        rst = 1'b0; run = 1'b0; load = 1'b0;
        load_hour = '0; load_minute = '0; load_second = '0;
        inc_hour = 1'b0; inc_minute = 1'b0;
`ifdef TIMEKEEPER_ALARM_EN
        alarm_arm = 1'b0; alarm_hour = '0; alarm_minute = '0; alarm_ack = 1'b0;
`endif
        #3;
        chk("reset", 0, 0, 0, 0, 0);
        #4 rst = 1'b1;

        // run=0 keeps the time frozen
        edges(3);
        chk("frozen", 0, 0, 0, 0, 0);

        // rollover: 23:59:58 -> 23:59:59 after 4 edges -> 00:00:00 after 8
        run = 1'b1;
        do_load(23, 59, 58);
        chk("roll.load", 23, 59, 58, 0, 0);
        n_pulse = 0;
        for (int i = 1; i <= 8; i++) begin
            edge1();
            if (sec_pulse) n_pulse++;
            if (i == 4) chk("roll.mid", 23, 59, 59, 1, 0);
        end
        chk("roll.end", 0, 0, 0, 1, 0);
        cmp("roll.pulses", 8'(n_pulse), 8'd2);

        // invalid loads change nothing and pulse load_err for one cycle
        run = 1'b0;
        do_load(24, 0, 0);
        chk("bad_hour", 0, 0, 0, 0, 1);
        edge1();
        chk("bad_hour.after", 0, 0, 0, 0, 0);
        do_load(12, 60, 0);
        chk("bad_min", 0, 0, 0, 0, 1);

        // invalid load coincident with a tick: the tick still applies
        run = 1'b1;
        edges(3);
        do_load(0, 0, 60);
        chk("bad_sec.tick", 0, 0, 1, 1, 1);

        // valid load in the wrap cycle discards the tick; next tick CLK_HZ edges later
        edges(3);
        chk("beat.pre3", 0, 0, 1, 0, 0);
        do_load(10, 20, 30);
        chk("beat.load", 10, 20, 30, 0, 0);
        edges(CLK_HZ - 1);
        chk("beat.wait", 10, 20, 30, 0, 0);
        edge1();
        chk("beat.tick", 10, 20, 31, 1, 0);

        // minute button coincident with the seconds carry: 59 + 2 -> 1, hour untouched
        do_load(5, 59, 59);
        edges(CLK_HZ - 1);
        inc_minute = 1'b1;
        edge1();
        chk("incmin.carry", 5, 1, 0, 1, 0);
        edge1();
        chk("incmin.level", 5, 1, 0, 0, 0);
        inc_minute = 1'b0;

        // hour button wraps 23 -> 0
        run = 1'b0;
        do_load(23, 15, 0);
        inc_hour = 1'b1;
        edge1();
        chk("inchour.wrap", 0, 15, 0, 0, 0);
        inc_hour = 1'b0;
        edge1();

        // hour button plus minute carry: 23 + 2 -> 1
        run = 1'b1;
        do_load(23, 59, 59);
        edges(CLK_HZ - 1);
        inc_hour = 1'b1;
        edge1();
        chk("inchour.double", 1, 0, 0, 1, 0);
        inc_hour = 1'b0;

        // button edge ignored when a valid load happens in the same cycle
        inc_minute = 1'b1;
        do_load(1, 2, 3);
        chk("inc_vs_load", 1, 2, 3, 0, 0);
        inc_minute = 1'b0;

        // asynchronous reset mid-count, then restart from pre=0
        do_load(7, 8, 9);
        edges(2);
        chk("rst.before", 7, 8, 9, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("rst.async", 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        // edge index after release at which the first sec_pulse becomes visible
        found = 0;
        for (int i = 1; i <= 20 && found == 0; i++) begin
            edge1();
            if (sec_pulse) found = i;
        end
        cmp("rst.pulse_edge", 8'(found), 8'(CLK_HZ));
        chk("rst.first", 0, 0, 1, 1, 0);

`ifdef TIMEKEEPER_ALARM_EN
        alarm_arm = 1'b1; alarm_hour = 6; alarm_minute = 30;
        do_load(6, 29, 59);
        cmp("alarm.idle", {7'b0, alarm}, 8'd0);
        edges(CLK_HZ);
        chk("alarm.time", 6, 30, 0, 1, 0);
        cmp("alarm.rise", {7'b0, alarm}, 8'd1);
        alarm_ack = 1'b1;
        edge1();
        alarm_ack = 1'b0;
        cmp("alarm.ack", {7'b0, alarm}, 8'd0);

        do_load(6, 29, 59);
        edges(CLK_HZ);
        cmp("alarm.rise2", {7'b0, alarm}, 8'd1);
        edges(59 * CLK_HZ);
        chk("alarm.hold", 6, 30, 59, 1, 0);
        cmp("alarm.hold", {7'b0, alarm}, 8'd1);
        edges(CLK_HZ);
        chk("alarm.silence", 6, 31, 0, 1, 0);
        cmp("alarm.silence", {7'b0, alarm}, 8'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
